// File: rtl/priority_decoder_dispatch_pkg.sv
// Shared types and sizes for the priority decoder dispatch block.
// The state enum, code width and line count are used by the top and the decoder.
package priority_decoder_dispatch_pkg;

    localparam int CODE_W    = 4;
    localparam int NUM_LINES = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/priority_decoder_dispatch_decoder_4to16.sv
// Combinational 4-to-16 one-hot decode; the parent registers the result.
module decoder_4to16
    import priority_decoder_dispatch_pkg::*;
(
    input  logic [CODE_W-1:0]    i_code,
    output logic [NUM_LINES-1:0] o_onehot
);

    for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
        assign o_onehot[gi] = (i_code == CODE_W'(gi));
    end

endmodule

// File: rtl/priority_decoder_dispatch.sv
// Accepts a 4-bit line code, drives a registered one-hot select until the target
// acknowledges, times out or is disabled, then waits for ack to drop before re-arming.
module priority_decoder_dispatch
    import priority_decoder_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 8
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    input  logic [3:0]           code,
    input  logic                 code_valid,
    output logic                 code_ready,
    output logic [15:0]          out,
    input  logic [15:0]          ack,
    output logic                 busy,
    output logic                 timeout,
    output logic [CNT_W-1:0]     dispatch_count
);

    localparam int               TMR_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t               r_state;
    logic [CODE_W-1:0]    r_sel;
    logic [TMR_W-1:0]     r_timer;
    logic [NUM_LINES-1:0] r_out;
    logic                 r_timeout;
    logic [CNT_W-1:0]     r_cnt;

    logic [NUM_LINES-1:0] w_dec;
    logic                 w_accept;
    logic                 w_ack_sel;

    decoder_4to16 u_dec (
        .i_code   (code),
        .o_onehot (w_dec)
    );

    assign code_ready = (r_state == IDLE) && !enable;
    assign w_accept   = code_valid && code_ready;
    // Only the selected line's acknowledge matters; all other bits are don't-care.
    assign w_ack_sel  = ack[r_sel];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_sel     <= '0;
            r_timer   <= '0;
            r_out     <= '0;
            r_timeout <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_sel   <= code;
                        r_out   <= w_dec;
                        r_timer <= '0;
                        r_state <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    // Priority: acknowledge, then abort by disable, then timeout.
                    if (w_ack_sel) begin
                        r_out   <= '0;
                        r_state <= RELEASE;
                        if (r_cnt != CNT_MAX) r_cnt <= r_cnt + CNT_W'(1);
                    end else if (enable) begin
                        r_out   <= '0;
                        r_state <= RELEASE;
                    end else if (r_timer == TMR_LAST) begin
                        r_out     <= '0;
                        r_timeout <= 1'b1;
                        r_state   <= RELEASE;
                    end else begin
                        r_timer <= r_timer + TMR_W'(1);
                    end
                end
                RELEASE: begin
                    if (!w_ack_sel) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign out            = r_out;
    assign busy           = (r_state != IDLE);
    assign timeout        = r_timeout;
    assign dispatch_count = r_cnt;

endmodule

// File: tb/tb_priority_decoder_dispatch.sv
// Bench for priority_decoder_dispatch: two instances (16-cycle/8-bit and 4-cycle/2-bit)
// share stimulus; directed scenarios then random traffic against a transaction-level model.
module tb_priority_decoder_dispatch;

    logic        clk = 1'b0;
    logic        rst_n, enable, code_valid;
    logic [3:0]  code;
    logic [15:0] ack;

    logic        rdy0, busy0, to0, rdy1, busy1, to1;
    logic [15:0] out0, out1;
    logic [7:0]  cnt0;
    logic [1:0]  cnt1;

    always #5 clk = ~clk;

    priority_decoder_dispatch #(.TIMEOUT_CYCLES(16), .CNT_W(8)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .code(code), .code_valid(code_valid),
        .code_ready(rdy0), .out(out0), .ack(ack), .busy(busy0), .timeout(to0),
        .dispatch_count(cnt0)
    );

    priority_decoder_dispatch #(.TIMEOUT_CYCLES(4), .CNT_W(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable(enable), .code(code), .code_valid(code_valid),
        .code_ready(rdy1), .out(out1), .ack(ack), .busy(busy1), .timeout(to1),
        .dispatch_count(cnt1)
    );

    localparam int TO_C [2] = '{16, 4};
    localparam int CMAX [2] = '{255, 3};

    // Model: phase 0 waiting, 1 driving a line, 2 waiting for ack to drop.
    int m_ph [2], m_sel [2], m_age [2], m_cnt [2], m_to [2];

    int n_chk = 0, n_err = 0;
    int n_watch, n_top, n_gap;
    logic [15:0] watch, prev1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_out(input int k);
        return (m_ph[k] == 1) ? (32'd1 << m_sel[k]) : 32'd0;
    endfunction

    task automatic mdl_step();
        for (int k = 0; k < 2; k++) begin
            logic a;
            a = ack[m_sel[k]];
            if (!rst_n) begin
                m_ph[k] = 0; m_sel[k] = 0; m_age[k] = 0; m_to[k] = 0; m_cnt[k] = 0;
            end else begin
                m_to[k] = 0;
                if (m_ph[k] == 0) begin
                    if (!enable && code_valid) begin
                        m_ph[k] = 1; m_sel[k] = int'(code); m_age[k] = 1;
                    end
                end else if (m_ph[k] == 1) begin
                    if (a) begin
                        if (m_cnt[k] < CMAX[k]) m_cnt[k]++;
                        m_ph[k] = 2;
                    end else if (enable) begin
                        m_ph[k] = 2;
                    end else if (m_age[k] == TO_C[k]) begin
                        m_to[k] = 1; m_ph[k] = 2;
                    end else begin
                        m_age[k]++;
                    end
                end else if (!a) begin
                    m_ph[k] = 0;
                end
            end
        end
    endtask

    task automatic step();
        #1;
        chk("rdy0", 32'(rdy0), 32'(m_ph[0] == 0 && !enable));
        chk("rdy1", 32'(rdy1), 32'(m_ph[1] == 0 && !enable));
        mdl_step();
        @(posedge clk);
        #1;
        chk("out0",  32'(out0),  exp_out(0));
        chk("busy0", 32'(busy0), 32'(m_ph[0] != 0));
        chk("to0",   32'(to0),   32'(m_to[0]));
        chk("cnt0",  32'(cnt0),  32'(m_cnt[0]));
        chk("out1",  32'(out1),  exp_out(1));
        chk("busy1", 32'(busy1), 32'(m_ph[1] != 0));
        chk("to1",   32'(to1),   32'(m_to[1]));
        chk("cnt1",  32'(cnt1),  32'(m_cnt[1]));
        if (out0 == watch) n_watch++;
        if (to0) n_top++;
        if (prev1 != 16'h0 && out1 != 16'h0 && out1 != prev1) n_gap++;
        prev1 = out1;
    endtask

    task automatic disp(input logic [3:0] c);
        code = c; code_valid = 1'b1; step();
        code_valid = 1'b0; ack = 16'h0001 << c; step();
        ack = 16'h0; step();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; enable = 1'b1; code_valid = 1'b0; code = 4'h0; ack = 16'h0;
        watch = 16'hFFFF; prev1 = 16'h0; n_watch = 0; n_top = 0; n_gap = 0;
        repeat (2) @(posedge clk);
        mdl_step();
        #1;
        chk("rst_out0",  32'(out0),  32'h0);
        chk("rst_cnt0",  32'(cnt0),  32'h0);
        chk("rst_busy0", 32'(busy0), 32'h0);
        chk("rst_to0",   32'(to0),   32'h0);
        chk("rst_cnt1",  32'(cnt1),  32'h0);

        // Basic dispatch on line 10
        rst_n = 1'b1; enable = 1'b0; n_top = 0;
        code = 4'hA; code_valid = 1'b1; step();
        chk("basic_out", 32'(out0), 32'h0400);
        code_valid = 1'b0; step(); step();
        ack = 16'h0400; step();
        chk("basic_clr", 32'(out0), 32'h0);
        ack = 16'h0; step(); step();
        chk("basic_cnt", 32'(cnt0), 32'd1);
        chk("basic_to",  32'(n_top), 32'd0);

        // Timeout on line 3
        watch = 16'h0008; n_watch = 0; n_top = 0;
        code = 4'h3; code_valid = 1'b1; step();
        code_valid = 1'b0;
        repeat (20) step();
        chk("to_hi_cycles", 32'(n_watch), 32'd16);
        chk("to_pulses",    32'(n_top),   32'd1);
        chk("to_cnt",       32'(cnt0),    32'd1);
        chk("to_busy",      32'(busy0),   32'd0);
        watch = 16'hFFFF;

        // Wrong-line acknowledge is ignored
        code = 4'h0; code_valid = 1'b1; step();
        code_valid = 1'b0; ack = 16'h0002;
        repeat (5) step();
        chk("wl_hold", 32'(out0), 32'h0001);
        chk("wl_cnt0", 32'(cnt0), 32'd1);
        ack = 16'h0003; step();
        chk("wl_cnt1", 32'(cnt0), 32'd2);
        ack = 16'h0; step(); step();

        // Acknowledge in the exact timeout cycle wins
        n_top = 0;
        code = 4'h5; code_valid = 1'b1; step();
        code_valid = 1'b0;
        repeat (15) step();
        ack = 16'h0020; step();
        chk("co_cnt", 32'(cnt0), 32'd3);
        ack = 16'h0; step(); step();
        chk("co_to", 32'(n_top), 32'd0);

        // Disable mid-ACTIVE aborts
        n_top = 0;
        code = 4'h7; code_valid = 1'b1; step();
        code_valid = 1'b0; step(); step();
        enable = 1'b1; step();
        chk("dis_out",  32'(out0),  32'h0);
        chk("dis_busy", 32'(busy0), 32'd1);
        enable = 1'b0; step(); step();
        chk("dis_to",  32'(n_top), 32'd0);
        chk("dis_cnt", 32'(cnt0),  32'd3);

        // Reset mid-ACTIVE with count 5, then immediate accept
        disp(4'h1); disp(4'h2);
        chk("pre_rst_cnt", 32'(cnt0), 32'd5);
        code = 4'h9; code_valid = 1'b1; step();
        code_valid = 1'b0; step();
        rst_n = 1'b0; step();
        chk("mrst_out",  32'(out0),  32'h0);
        chk("mrst_cnt",  32'(cnt0),  32'h0);
        chk("mrst_busy", 32'(busy0), 32'h0);
        chk("mrst_to",   32'(to0),   32'h0);
        rst_n = 1'b1; code = 4'hC; code_valid = 1'b1; step();
        chk("rst_acc", 32'(out0), 32'h1000);
        code_valid = 1'b0; ack = 16'h1000; step();
        ack = 16'h0; step();

        // Back-to-back dispatches saturate the 2-bit counter
        n_gap = 0; prev1 = 16'h0; code_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            code = 4'(i + 1); step();
            ack = 16'h0001 << (i + 1); step();
            ack = 16'h0; step();
        end
        code_valid = 1'b0; step();
        chk("sat_cnt1", 32'(cnt1),  32'd3);
        chk("sat_gap",  32'(n_gap), 32'd0);

        // Random traffic
        for (int i = 0; i < 1500; i++) begin
            rst_n      = ($urandom_range(0, 99) != 0);
            enable     = ($urandom_range(0, 7) == 0);
            code_valid = $urandom_range(0, 1) == 1;
            code       = 4'($urandom_range(0, 15));
            ack        = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/priority_decoder_dispatch.md
PRIORITY_DECODER_DISPATCH -- requirements
Module: priority_decoder_dispatch

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the number of ACTIVE cycles to wait for acknowledge before abandoning a dispatch (legal range 2..255).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the completed-dispatch counter.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit, reset that is synchronous and active-low.
REQ-005 SHALL have port enable, input, 1 bit, block enable that is active-low (0 = enabled).
REQ-006 SHALL have port code, input, 4 bits, encoded line index 0..15, with bit 3 as the MSB.
REQ-007 SHALL have port code_valid, input, 1 bit, asserted when code holds a valid index.
REQ-008 SHALL have port code_ready, output, 1 bit, asserted when the block accepts a code this cycle.
REQ-009 SHALL have port out, output, 16 bits, registered one-hot select; out[i] corresponds to code==i.
REQ-010 SHALL have port ack, input, 16 bits, per-line acknowledge from the selected targets.
REQ-011 SHALL have port busy, output, 1 bit, high whenever the state is not IDLE.
REQ-012 SHALL have port timeout, output, 1 bit, a registered single-cycle pulse raised on an acknowledge timeout.
REQ-013 SHALL have port dispatch_count, output, CNT_W bits, the count of acknowledged dispatches.

Function
REQ-014 SHALL implement a state machine with three states: IDLE, ACTIVE and RELEASE.
REQ-015 code_ready SHALL be combinational and equal (state==IDLE) AND (enable==0).
REQ-016 A transfer SHALL occur on a rising edge where code_valid and code_ready are both 1. On that edge:
- code is latched into sel;
- out becomes one-hot (1 shifted left by code) in the following cycle;
- the timer clears to 0;
- the state moves to ACTIVE.
REQ-017 In IDLE and RELEASE, out SHALL be all zeros. In ACTIVE, out SHALL hold exactly one bit set, at position sel, and stay stable.
REQ-018 In ACTIVE, if ack[sel]==1: out clears to 0, dispatch_count increments, and the state moves to RELEASE.
- dispatch_count saturates at all-ones and does not wrap.
REQ-019 In ACTIVE with ack[sel]==0, the timer SHALL increment each cycle. When the timer equals TIMEOUT_CYCLES-1 and ack[sel]==0:
- out clears to 0;
- timeout pulses high for exactly the next cycle;
- the state moves to RELEASE;
- dispatch_count is unchanged.
REQ-020 Acknowledge bits other than ack[sel] SHALL be ignored in every state.
REQ-021 If ack[sel] rises in the same cycle the timeout limit is reached, acknowledge SHALL win: the count increments and no timeout pulse is raised.
REQ-022 If enable goes to 1 during ACTIVE, the block SHALL abort on the next edge:
- out clears;
- the state moves to RELEASE;
- no count increment and no timeout pulse;
- abort has lower priority than acknowledge in the same cycle.
REQ-023 RELEASE SHALL remain until ack[sel]==0 (four-phase handshake), then go to IDLE on that edge. RELEASE therefore always lasts at least one cycle, so back-to-back dispatches are separated by at least one zero cycle on out.
REQ-024 Latency: a code accepted at edge N SHALL be visible on out during cycle N+1. The minimum cycle-to-cycle dispatch period is 3 cycles.
REQ-025 When enable==1 in IDLE, code_valid SHALL be ignored, code_ready SHALL be 0, and all outputs SHALL hold their values.

Reset
REQ-026 While rst_n==0 at a rising edge, the block SHALL load the following, overriding all other activity including mid-ACTIVE:
- state = IDLE;
- out = 0;
- sel = 0;
- timer = 0;
- timeout = 0;
- dispatch_count = 0.
REQ-027 No acknowledge wait SHALL survive reset; the first accept after reset SHALL be possible in the first cycle that has rst_n==1 and enable==0.

Structure
REQ-028 A shared package SHALL hold the state enumeration (IDLE, ACTIVE, RELEASE), the code width (4) and the line count (16).
REQ-029 The 4-to-16 one-hot decode SHALL be a separate combinational sub-module, decoder_4to16. It is instantiated once, and its output is registered in the parent.
REQ-030 The timer SHALL be sized ceil(log2(TIMEOUT_CYCLES)) bits and SHALL never wrap within ACTIVE.

Verification
REQ-031 Basic dispatch: enable=0, code=4'hA with valid for 1 cycle, ack[10]=1 three cycles later. Required response:
- out=16'h0400 from the cycle after accept;
- out returns to 0 after ack;
- dispatch_count=1;
- timeout never asserted.
REQ-032 Timeout: code=4'h3 and no ack, with TIMEOUT_CYCLES=16. Required response:
- out=16'h0008 for exactly 16 cycles;
- timeout is high for 1 cycle;
- dispatch_count stays 0;
- busy falls after RELEASE.
REQ-033 Wrong-line ack: code=4'h0 with ack[1]=1 held. Required response: out stays 16'h0001 until ack[0]=1; only then does dispatch_count become 1.
REQ-034 Coincidence: ack[sel] rises in the exact timeout cycle. Required response: dispatch_count increments and timeout stays 0.
REQ-035 Disable and reset: enable=1 mid-ACTIVE causes out to go to 0 next cycle with no count and no timeout. A separate run drives rst_n=0 mid-ACTIVE with dispatch_count=5; required response is that all outputs are 0 and state is IDLE at the next edge.
REQ-036 Saturation and back-to-back: CNT_W=2, five acknowledged dispatches with ack dropping immediately. Required response: dispatch_count saturates at 3, and out goes to 0 for at least one cycle between consecutive one-hot values.
